// File: rtl/bb84_sift_engine.sv
// BB84 receiver-side sifting engine.
// Collects FRAME_LEN qubits. A qubit is kept when the sender base matches
// Bob's base, and each kept bit is packed LSB-first into a KEY_W-bit key.
// The engine counts ignored qubits, flags kept bits that no longer fit in
// the key, and holds the finished key until the consumer acknowledges it.
module bb84_sift_engine #(
   parameter  int FRAME_LEN = 16,
   parameter  int KEY_W     = 16,
   localparam int IDX_W     = $clog2(FRAME_LEN + 1),
   localparam int LEN_W     = $clog2(KEY_W + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             abort,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       public_msg,
   input  logic             b_dash,
   output logic             sift_valid,
   output logic             sift_bit,
   output logic             sift_ignore,
   output logic [KEY_W-1:0] key_out,
   output logic [LEN_W-1:0] key_len,
   output logic [IDX_W-1:0] ignore_cnt,
   output logic             overflow,
   output logic             key_valid,
   input  logic             key_ack,
   output logic             busy
);

   typedef enum logic [1:0] {ST_IDLE, ST_COLLECT, ST_HOLD} state_t;

   localparam logic [LEN_W-1:0] KEY_FULL = LEN_W'(KEY_W);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(FRAME_LEN - 1);

   state_t             state_q, state_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [KEY_W-1:0]   key_q, key_d;
   logic [LEN_W-1:0]   len_q, len_d;
   logic [IDX_W-1:0]   ign_q, ign_d;
   logic               ovf_q, ovf_d;
   logic               sv_q, sv_d;
   logic               sb_q, sb_d;
   logic               si_q, si_d;
   logic               match;

   // Sender base word bit 0 compared against Bob's base.
   assign match = (public_msg[0] == b_dash);

   // Next-state and datapath update; abort overrides every other event.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      key_d   = key_q;
      len_d   = len_q;
      ign_d   = ign_q;
      ovf_d   = ovf_q;
      sv_d    = 1'b0;
      sb_d    = 1'b0;
      si_d    = 1'b0;
      if (abort) begin
         state_d = ST_IDLE;
         idx_d   = '0;
         key_d   = '0;
         len_d   = '0;
         ign_d   = '0;
         ovf_d   = 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  state_d = ST_COLLECT;
                  idx_d   = '0;
                  key_d   = '0;
                  len_d   = '0;
                  ign_d   = '0;
                  ovf_d   = 1'b0;
               end
            end
            ST_COLLECT: begin
               if (in_valid) begin
                  sv_d = 1'b1;
                  if (match) begin
                     sb_d = public_msg[1];
                     if (len_q < KEY_FULL) begin
                        key_d[len_q] = public_msg[1];
                        len_d        = len_q + 1'b1;
                     end else begin
                        // Key register full: the bit is lost, remember that.
                        ovf_d = 1'b1;
                     end
                  end else begin
                     si_d  = 1'b1;
                     ign_d = ign_q + 1'b1;
                  end
                  idx_d = idx_q + 1'b1;
                  if (idx_q == IDX_LAST) state_d = ST_HOLD;
               end
            end
            ST_HOLD: begin
               if (key_ack) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   // State and datapath registers, cleared asynchronously.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         idx_q   <= '0;
         key_q   <= '0;
         len_q   <= '0;
         ign_q   <= '0;
         ovf_q   <= 1'b0;
         sv_q    <= 1'b0;
         sb_q    <= 1'b0;
         si_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         key_q   <= key_d;
         len_q   <= len_d;
         ign_q   <= ign_d;
         ovf_q   <= ovf_d;
         sv_q    <= sv_d;
         sb_q    <= sb_d;
         si_q    <= si_d;
      end
   end

   assign in_ready    = (state_q == ST_COLLECT);
   assign key_valid   = (state_q == ST_HOLD);
   assign busy        = (state_q != ST_IDLE);
   assign sift_valid  = sv_q;
   assign sift_bit    = sb_q;
   assign sift_ignore = si_q;
   assign key_out     = key_q;
   assign key_len     = len_q;
   assign ignore_cnt  = ign_q;
   assign overflow    = ovf_q;

endmodule

// File: tb/tb_bb84_sift_engine.sv
// Bench for bb84_sift_engine: two instances (KEY_W=4 and KEY_W=2, both
// FRAME_LEN=4) share one stimulus stream. A queue-based model of the
// accepted qubits of the current frame gives the expected outputs of both.
module tb_bb84_sift_engine;

   localparam int FL = 4;

   logic clk = 1'b0;
   logic rst_n, start, abort, in_valid, b_dash, key_ack;
   logic [1:0] public_msg;

   logic       rdy_a, sv_a, sb_a, si_a, ovf_a, kv_a, busy_a;
   logic [3:0] key_a;
   logic [2:0] len_a, ign_a;
   logic       rdy_b, sv_b, sb_b, si_b, ovf_b, kv_b, busy_b;
   logic [1:0] key_b;
   logic [1:0] len_b;
   logic [2:0] ign_b;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   bb84_sift_engine #(.FRAME_LEN(FL), .KEY_W(4)) dut_a (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
      .in_valid(in_valid), .in_ready(rdy_a), .public_msg(public_msg),
      .b_dash(b_dash), .sift_valid(sv_a), .sift_bit(sb_a),
      .sift_ignore(si_a), .key_out(key_a), .key_len(len_a),
      .ignore_cnt(ign_a), .overflow(ovf_a), .key_valid(kv_a),
      .key_ack(key_ack), .busy(busy_a));

   bb84_sift_engine #(.FRAME_LEN(FL), .KEY_W(2)) dut_b (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
      .in_valid(in_valid), .in_ready(rdy_b), .public_msg(public_msg),
      .b_dash(b_dash), .sift_valid(sv_b), .sift_bit(sb_b),
      .sift_ignore(si_b), .key_out(key_b), .key_len(len_b),
      .ignore_cnt(ign_b), .overflow(ovf_b), .key_valid(kv_b),
      .key_ack(key_ack), .busy(busy_b));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         if (failures <= 40)
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   int phase;        // 0 idle, 1 collecting, 2 holding finished key
   bit mq[$];        // per accepted qubit: bases matched
   bit bq[$];        // per accepted qubit: sender bit
   bit e_sv, e_sb, e_si;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         phase = 0; mq.delete(); bq.delete();
         e_sv = 0; e_sb = 0; e_si = 0;
      end else begin
         e_sv = 0; e_sb = 0; e_si = 0;
         if (abort) begin
            phase = 0; mq.delete(); bq.delete();
         end else if (phase == 0) begin
            if (start) begin phase = 1; mq.delete(); bq.delete(); end
         end else if (phase == 1) begin
            if (in_valid) begin
               bit m;
               m = (public_msg[0] == b_dash);
               mq.push_back(m);
               bq.push_back(public_msg[1]);
               e_sv = 1; e_si = !m; e_sb = m & public_msg[1];
               if (mq.size() == FL) phase = 2;
            end
         end else if (key_ack) begin
            phase = 0;
         end
      end
   end

   // Key statistics of the frame so far for a key register of kw bits.
   function automatic void model_key(input int kw, output logic [31:0] key,
                                     output int len, output int ovf, output int ign);
      int n;
      key = '0; n = 0; ign = 0;
      for (int i = 0; i < mq.size(); i++) begin
         if (mq[i]) begin
            if (n < kw) key[n] = bq[i];
            n++;
         end else ign++;
      end
      len = (n < kw) ? n : kw;
      ovf = (n > kw) ? 1 : 0;
   endfunction

   // Every cycle, both instances against the model.
   always @(negedge clk) begin : cmp
      logic [31:0] k;
      int l, o, ig;
      model_key(4, k, l, o, ig);
      chk("a.in_ready", rdy_a, phase == 1);
      chk("a.busy", busy_a, phase != 0);
      chk("a.key_valid", kv_a, phase == 2);
      chk("a.sift_valid", sv_a, e_sv);
      chk("a.sift_bit", sb_a, e_sb);
      chk("a.sift_ignore", si_a, e_si);
      chk("a.key_out", key_a, k & 32'hF);
      chk("a.key_len", len_a, l);
      chk("a.ignore_cnt", ign_a, ig);
      chk("a.overflow", ovf_a, o);
      model_key(2, k, l, o, ig);
      chk("b.key_valid", kv_b, phase == 2);
      chk("b.sift_bit", sb_b, e_sb);
      chk("b.key_out", key_b, k & 32'h3);
      chk("b.key_len", len_b, l);
      chk("b.ignore_cnt", ign_b, ig);
      chk("b.overflow", ovf_b, o);
   end

   // ---------------- stimulus ----------------
   task automatic qubit(input logic [1:0] m, input logic b, input logic v);
      in_valid = v; public_msg = m; b_dash = b;
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic do_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic do_ack();
      key_ack = 1'b1;
      @(negedge clk);
      key_ack = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; start = 0; abort = 0; in_valid = 0; b_dash = 0;
      key_ack = 0; public_msg = 2'b00;
      repeat (2) @(negedge clk);
      chk("lit.reset_key", {key_a, len_a, ign_a, ovf_a, kv_a, busy_a, rdy_a}, 0);
      rst_n = 1'b1;
      @(negedge clk);

      // Mixed bases: ignore pattern 0,1,0,1.
      do_start();
      qubit(2'b00, 0, 1); qubit(2'b10, 1, 1); qubit(2'b11, 1, 1); qubit(2'b01, 0, 1);
      chk("lit.t1_key_valid", kv_a, 1);
      chk("lit.t1_key_a", key_a, 4'b0010);
      chk("lit.t1_len_a", len_a, 2);
      chk("lit.t1_ign_a", ign_a, 2);
      chk("lit.t1_ovf_a", ovf_a, 0);
      chk("lit.t1_key_b", key_b, 2'b10);
      do_ack();
      chk("lit.t1_idle", busy_a, 0);

      // All matching, bits 1,0,1,1: KEY_W=2 overflows.
      do_start();
      qubit(2'b10, 0, 1); qubit(2'b00, 0, 1); qubit(2'b10, 0, 1); qubit(2'b10, 0, 1);
      chk("lit.t2_key_b", key_b, 2'b01);
      chk("lit.t2_len_b", len_b, 2);
      chk("lit.t2_ovf_b", ovf_b, 1);
      chk("lit.t2_ign_b", ign_b, 0);
      chk("lit.t2_key_a", key_a, 4'b1101);
      chk("lit.t2_ovf_a", ovf_a, 0);
      // Words offered in HOLD are not taken.
      qubit(2'b01, 0, 1); qubit(2'b00, 0, 1);
      chk("lit.t2_hold_key", key_a, 4'b1101);
      do_ack();

      // in_valid toggling 1,0,1,0...
      do_start();
      for (int i = 0; i < 8; i++) begin
         if (i == 7) chk("lit.t3_kv_after4", kv_a, 1);
         qubit(2'($urandom), 1'($urandom), (i % 2) == 0);
      end
      do_ack();

      // Abort alongside the second accept.
      do_start();
      qubit(2'b10, 0, 1);
      abort = 1'b1;
      qubit(2'b11, 1, 1);
      abort = 1'b0;
      chk("lit.t4_busy", busy_a, 0);
      chk("lit.t4_len", len_a, 0);
      chk("lit.t4_ign", ign_a, 0);
      do_start();
      qubit(2'b11, 1, 1); qubit(2'b11, 1, 1); qubit(2'b01, 1, 1); qubit(2'b00, 1, 1);
      chk("lit.t4_key", key_a, 4'b0011);
      do_ack();

      // Asynchronous reset after three accepts.
      do_start();
      qubit(2'b10, 0, 1); qubit(2'b11, 1, 1); qubit(2'b01, 0, 1);
      #2 rst_n = 1'b0; start = 1'b1;
      #1 chk("lit.t5_async", {key_a, len_a, ign_a, ovf_a, busy_a, rdy_a, sv_a}, 0);
      @(negedge clk);
      chk("lit.t5_start_in_rst", busy_a, 0);
      start = 1'b0; rst_n = 1'b1;
      @(negedge clk);

      // start held through HOLD: one new frame after the ack.
      start = 1'b1;
      @(negedge clk);
      qubit(2'b00, 0, 1); qubit(2'b00, 1, 1); qubit(2'b11, 1, 1); qubit(2'b01, 0, 1);
      @(negedge clk);
      chk("lit.t6_hold", kv_a, 1);
      do_ack();
      chk("lit.t6_idle", busy_a, 0);
      @(negedge clk);
      start = 1'b0;
      chk("lit.t6_restart", rdy_a, 1);
      chk("lit.t6_cleared", len_a, 0);
      repeat (4) qubit(2'($urandom), 1'($urandom), 1);
      do_ack();

      // Randomized traffic.
      for (int c = 0; c < 2000; c++) begin
         start      = ($urandom % 4) == 0;
         in_valid   = ($urandom % 3) != 0;
         public_msg = 2'($urandom);
         b_dash     = 1'($urandom);
         abort      = ($urandom % 60) == 0;
         key_ack    = ($urandom % 3) == 0;
         @(negedge clk);
      end
      start = 0; in_valid = 0; key_ack = 0; abort = 0;
      @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
